// File: rtl/awg_pkg.sv
// Shared types and widths for the triangle/DAC waveform generator sequencer.
package awg_pkg;

    localparam int FREQ_W = 14;
    localparam int AMP_W  = 8;
    localparam int PH_W   = 8;
    localparam int BLEN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        STOP
    } state_t;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [AMP_W-1:0]  amp;
        logic [PH_W-1:0]   phase;
    } cfg_t;

endpackage

// File: rtl/wave_seq_ctrl_if.sv
// Configuration handshake, run control and generator-facing outputs of wave_seq_ctrl.
interface wave_seq_ctrl_if
    import awg_pkg::*;
#(
    parameter int CNT_W = 14
);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [FREQ_W-1:0] cfg_freq;
    logic [AMP_W-1:0]  cfg_amp;
    logic [PH_W-1:0]   cfg_phase;
    logic              run;
    logic [BLEN_W-1:0] burst_len;
    logic              en;
    logic [CNT_W-1:0]  cnt;
    logic [FREQ_W-1:0] state_freq;
    logic [AMP_W-1:0]  state_amp;
    logic [PH_W-1:0]   state_phase;
    logic              busy;
    logic              done;

    modport master (
        output cfg_valid, cfg_freq, cfg_amp, cfg_phase, run, burst_len,
        input  cfg_ready, en, cnt, state_freq, state_amp, state_phase, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_freq, cfg_amp, cfg_phase, run, burst_len,
        output cfg_ready, en, cnt, state_freq, state_amp, state_phase, busy, done
    );

endinterface

// File: rtl/phase_acc.sv
// Phase accumulator: adds the frequency word every stepped cycle and flags the carry-out
// as the period boundary. Only the top CNT_W bits leave the block.
module phase_acc
    import awg_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_step,
    input  logic [FREQ_W-1:0] i_inc,
    output logic [CNT_W-1:0]  o_accTop,
    output logic              o_wrap
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - FREQ_W){1'b0}}, i_inc};
    assign o_wrap   = w_sum[ACC_W];
    assign o_accTop = r_acc[ACC_W-1 -: CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/wave_seq_ctrl.sv
// Sequencer for the waveform generator: run/burst FSM, active and pending configuration,
// and the phase-offset counter output. New settings only take effect on period boundaries.
module wave_seq_ctrl
    import awg_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    wave_seq_ctrl_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    cfg_t              r_cfg;
    cfg_t              r_pend;
    logic              r_pendValid;
    logic [BLEN_W-1:0] r_periods;
    logic [BLEN_W-1:0] r_blen;
    cfg_t              w_cfgIn;
    logic              w_accept;
    logic              w_carry;
    logic              w_wrap;
    logic              w_burstEnd;
    logic [CNT_W-1:0]  w_accTop;
    logic [CNT_W-1:0]  w_phOff;

    phase_acc #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_phase_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != RUN),
        .i_step   (r_state == RUN),
        .i_inc    (r_cfg.freq),
        .o_accTop (w_accTop),
        .o_wrap   (w_carry)
    );

    assign w_cfgIn    = {bus.cfg_freq, bus.cfg_amp, bus.cfg_phase};
    assign w_accept   = bus.cfg_valid && bus.cfg_ready;
    assign w_wrap     = w_carry && (r_state == RUN);
    assign w_burstEnd = (r_blen != '0) && ((r_periods + BLEN_W'(1)) == r_blen);
    assign w_phOff    = {r_cfg.phase, {(CNT_W - PH_W){1'b0}}};

    // Ready reads low during reset and while a run-time update waits for its boundary
    assign bus.cfg_ready   = rst_n && !r_pendValid;
    assign bus.en          = (r_state == RUN);
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == STOP);
    assign bus.cnt         = (r_state == RUN) ? (w_accTop + w_phOff) : '0;
    assign bus.state_freq  = r_cfg.freq;
    assign bus.state_amp   = r_cfg.amp;
    assign bus.state_phase = r_cfg.phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero frequency never wraps, so a stop request is honoured at once in that case
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.run) w_next = ARM;
            ARM:  w_next = RUN;
            RUN: begin
                if (!bus.run && (r_cfg.freq == '0)) begin
                    w_next = STOP;
                end else if (w_wrap && (!bus.run || w_burstEnd)) begin
                    w_next = STOP;
                end
            end
            STOP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_periods <= '0;
            r_blen    <= '0;
        end else if (r_state == ARM) begin
            r_periods <= '0;
            r_blen    <= bus.burst_len;
        end else if (w_wrap) begin
            r_periods <= r_periods + BLEN_W'(1);
        end
    end

    // Acceptance requires an empty pending slot, so promotion and capture never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg       <= '0;
            r_pend      <= '0;
            r_pendValid <= 1'b0;
        end else begin
            if (r_pendValid && (w_wrap || (r_state == STOP) || (r_state == ARM))) begin
                r_cfg       <= r_pend;
                r_pendValid <= 1'b0;
            end
            if (w_accept) begin
                if (r_state == RUN) begin
                    r_pend      <= w_cfgIn;
                    r_pendValid <= 1'b1;
                end else begin
                    r_cfg <= w_cfgIn;
                end
            end
        end
    end

endmodule

// File: doc/wave_seq_ctrl.md
# wave_seq_ctrl

Sequencer and configuration controller for the triangle/DAC waveform generator. Owns the phase accumulator that produces the generator's `cnt` input and the generator enable. Holds the active frequency, amplitude and phase settings and accepts new ones through a valid/ready handshake. Updates are applied only at period boundaries, so the DAC never sees a mid-period discontinuity. Supports continuous and N-period burst output.

## Interface

**Parameters**
- `ACC_W`, default 24 — phase accumulator width. Must be ≥ 15.
- `CNT_W`, default 14 — generator counter width. Equals the DAC width.

**Ports**
- `clk` — input, 1 — system clock. All logic is on the rising edge.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `cfg_valid` — input, 1 — new configuration offered.
- `cfg_ready` — output, 1 — controller can accept a configuration.
- `cfg_freq` — input, 14 — phase increment per clock.
- `cfg_amp` — input, 8 — amplitude setting, passed through to the generator.
- `cfg_phase` — input, 8 — phase offset, in 1/256 of a period.
- `run` — input, 1 — level. High requests output; low requests stop.
- `burst_len` — input, 16 — periods per run. 0 means continuous. Sampled in ARM.
- `en` — output, 1 — generator enable.
- `cnt` — output, CNT_W — generator phase counter.
- `state_freq` — output, 14 — active setting.
- `state_amp` — output, 8 — active setting.
- `state_phase` — output, 8 — active setting.
- `busy` — output, 1 — high when the FSM is not in IDLE.
- `done` — output, 1 — one-cycle pulse when a run ends.

## Operation

**FSM states**
- **IDLE**
  - `en`=0, `acc`=0.
  - `cfg_ready`=1. An accepted configuration loads `state_*` on the next edge.
  - `run`=1 moves to ARM.
- **ARM** (1 cycle)
  - Clears `acc` and the period counter. Latches `burst_len` into `blen`.
  - Promotes any pending configuration to `state_*`.
  - Moves to RUN.
- **RUN**
  - `en`=1. Each cycle: `acc <= acc + state_freq` (zero-extended, mod 2^ACC_W).
  - `wrap` = carry out of that add.
  - On `wrap`, the period counter increments.
  - Moves to STOP on `wrap` when either:
    - `run`=0, or
    - `blen`≠0 and the counter reaches `blen`.
  - If `state_freq`=0 and `run`=0, moves to STOP immediately. No wrap can occur at zero frequency.
- **STOP** (1 cycle)
  - `en`=0, `done`=1.
  - Moves to IDLE, even if `run` is still high. A new run needs `run` to re-enter from IDLE on the following cycle. A level-high `run` therefore restarts after one IDLE cycle.

**Counter output**
- `cnt` = `acc[ACC_W-1 -: CNT_W]` + {`state_phase`, 6'b0}, mod 2^CNT_W.
- It is a pure function of registers, with no combinational input path.
- In IDLE, STOP and reset, `cnt` is forced to 0.

**Configuration handshake**
- A transfer occurs when `cfg_valid` && `cfg_ready` on a clock edge.
- In RUN, an accepted configuration goes to a single pending register.
  - `cfg_ready` drops until the pending value is applied at the next `wrap`.
  - On that `wrap` edge, `acc` continues from its wrapped value; it is not cleared.
- If acceptance and `wrap` coincide, the new configuration applies at the following `wrap`, not the current one.
- A pending configuration left when leaving RUN is applied in STOP.
- `cfg_valid` may be held. Data must be stable while valid && !ready.

**Reset**
- `rst_n` low at any time forces IDLE with all registers zeroed. This includes mid-period and mid-handshake; a pending configuration is discarded.
- Reset values:
  - `en`=0, `cnt`=0, `state_*`=0, `cfg_ready`=1, `busy`=0, `done`=0.
  - `cfg_ready` is 1 only once reset is released; while `rst_n` is low it is 0.

## Timing

- `run` rises at edge k (sampled in IDLE):
  - ARM at k+1.
  - RUN from k+2, with `en`=1 and `cnt`=phase offset in that first cycle.
- First `acc` step is at k+3.
- Period = 2^ACC_W / `state_freq` cycles, exact only when `state_freq` is a power of two.
- The `cnt` step per cycle is `state_freq` >> (ACC_W−CNT_W).
- `done` is asserted in the cycle after the terminating `wrap`. `en` falls in that same cycle.
- A configuration applied at a `wrap` edge appears on `state_*` in the same cycle as the wrapped `cnt`.

## Structure

- Shared package `awg_pkg`:
  - FSM state enum: IDLE, ARM, RUN, STOP.
  - Widths: FREQ_W=14, AMP_W=8, PH_W=8.
  - A `cfg_t` struct holding {freq, amp, phase}.
- One natural sub-module: `phase_acc`, containing the accumulator register, add-with-carry and `wrap` output.
- The FSM, pending register and period counter stay in the top level.

## Test plan

1. **Reset and idle configuration.** Reset, then in IDLE write freq=4096, amp=128, phase=0; `run`=1 with `burst_len`=0.
   - `state_*` updates one cycle after the handshake.
   - `en` rises 2 cycles after `run` is sampled.
   - `cnt` goes 0,4,8,… and wraps every 4096 cycles.
2. **Burst.** `burst_len`=2, freq=4096.
   - Exactly 8192 RUN cycles.
   - `done` pulses once. `busy` falls the cycle after `done`.
3. **Mid-run update.** Offer freq=8192 in RUN.
   - `cfg_ready` drops.
   - The step becomes 8 only after the next `wrap`, and `cfg_ready` then returns to 1.
   - Repeat with the offer timed on the exact `wrap` cycle: the update is deferred one full period.
4. **Phase offset.** phase=64: first RUN `cnt`=4096. phase=255 with an `acc` top value of 16383: `cnt` wraps mod 2^14 to 16319.
5. **Stop requests.**
   - `run` dropped mid-period: stops at the next `wrap`.
   - freq=0 and `run`=0: STOP the next cycle.
6. **Reset mid-run.** Assert `rst_n`=0 mid-run with a configuration pending.
   - All outputs go to their reset values asynchronously.
   - After release, `state_*` are 0 (the pending configuration is discarded).
